aes_inv_cipher_iter: RTL



---
 rtl/aes_inv_cipher_iter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128/192/256 inverse cipher with valid/ready handshakes.
// Optional macro AES_INV_TWO_ROUND_EN unrolls the datapath to two rounds per RUN cycle.
module aes_inv_cipher_iter #(
    parameter int MAX_NR = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              cipher_in,
    input  logic [3:0]                nr_in,
    input  logic [128*(MAX_NR+1)-1:0] rk_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              plain_out,
    output logic                      err_out
);
    localparam int RKW = 128 * (MAX_NR + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         accept, nr_legal;
`ifdef AES_INV_TWO_ROUND_EN
    logic [127:0] mid;
`endif

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254.
    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        logic [7:0] y, p, r;
        for (int i = 0; i < 8; i++)
            y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        y = y ^ 8'h05;
        p = y;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] imc_coef(input int d);
        case (d)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[127 - 8 * (j + 4 * c) -: 8], imc_coef((j - r + 4) % 4));
                o[127 - 8 * (r + 4 * c) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [127:0] t;
        t = inv_shift_rows(s);
        for (int b = 0; b < 16; b++) t[8 * b +: 8] = inv_sub_byte(t[8 * b +: 8]);
        t = t ^ k;
        return last ? t : inv_mix_columns(t);
    endfunction

    function automatic logic [127:0] rk_sel(input logic [RKW-1:0] rk, input logic [3:0] idx);
        logic [127:0] k;
        k = '0;
        for (int r = 0; r <= MAX_NR; r++)
            if (idx == 4'(r)) k = rk[128 * r +: 128];
        return k;
    endfunction

    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign nr_legal  = ((nr_in == 4'd10) || (nr_in == 4'd12) || (nr_in == 4'd14))
                       && (int'(nr_in) <= MAX_NR);
    assign out_valid = (fsm_q == DONE);
    assign plain_out = state_q;
    assign err_out   = err_q;

    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef AES_INV_TWO_ROUND_EN
        mid     = inv_round(state_q, rk_sel(rk_in, cnt_q), 1'b0);
`endif
        case (fsm_q)
            RUN: begin
`ifdef AES_INV_TWO_ROUND_EN
                if (cnt_q == 4'd0) begin
                    state_d = inv_round(state_q, rk_sel(rk_in, 4'd0), 1'b1);
                    fsm_d   = DONE;
                end else if (cnt_q == 4'd1) begin
                    state_d = inv_round(mid, rk_sel(rk_in, 4'd0), 1'b1);
                    cnt_d   = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    state_d = inv_round(mid, rk_sel(rk_in, cnt_q - 4'd1), 1'b0);
                    cnt_d   = cnt_q - 4'd2;
                end
`else
                if (cnt_q == 4'd0) begin
                    state_d = inv_round(state_q, rk_sel(rk_in, 4'd0), 1'b1);
                    fsm_d   = DONE;
                end else begin
                    state_d = inv_round(state_q, rk_sel(rk_in, cnt_q), 1'b0);
                    cnt_d   = cnt_q - 4'd1;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                    err_d = 1'b0;
                end
            end
            default: ;
        endcase
        // An accept in DONE overrides the retire above: same-edge handover.
        if (accept) begin
            if (nr_legal) begin
                fsm_d   = RUN;
                state_d = cipher_in ^ rk_sel(rk_in, nr_in);
                cnt_d   = nr_in - 4'd1;
                err_d   = 1'b0;
            end else begin
                fsm_d   = DONE;
                state_d = '0;
                cnt_d   = 4'd0;
                err_d   = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values;
    // state_q is reset too because plain_out must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule
